// File: rtl/endnode_tx_scheduler.sv
// Endnode TX scheduler: arbitrates credit grants, ACK komma flits and data
// packets onto one PHY TX port, with ACK FIFO, per-VC credits and a watchdog.
module endnode_tx_scheduler #(
    parameter int ACK_DEPTH = 4,     // power of 2, >= 2
    parameter int CRED_W    = 4,
    parameter int HOLD_CYC  = 2,
    parameter int TIMEOUT   = 1024,
    parameter int FLIT_W    = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              tx_idle,
    input  logic              get_data,
    input  logic              data_req,
    input  logic [FLIT_W-1:0] data_flit,
    input  logic              data_last,
    output logic              data_pop,
    input  logic              ack_push,
    input  logic [FLIT_W-1:0] ack_flit,
    output logic              ack_full,
    input  logic [1:0]        cred_ret,
    output logic [FLIT_W-1:0] flit_tx,
    output logic              start_tx,
    output logic              done_tx,
    output logic              packet_done_tx,
    output logic [1:0]        grtcred_tx,
    output logic              ack_drop,
    output logic              cred_ovf,
    output logic              timeout_err
);

    localparam int AW = $clog2(ACK_DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = $clog2(HOLD_CYC + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]     FULL_CNT  = CW'(ACK_DEPTH);
    localparam logic [HW-1:0]     HOLD_LAST = HW'(HOLD_CYC - 1);
    localparam logic [WW-1:0]     WD_LAST   = WW'(TIMEOUT - 1);
    localparam logic [CRED_W-1:0] CRED_MAX  = '1;

    typedef enum logic [1:0] {IDLE, SEND_DATA, HOLD} state_t;

    state_t                 state, state_nx;
    logic [FLIT_W-1:0]      fifo_mem [ACK_DEPTH];
    logic [AW-1:0]          rd_ptr, wr_ptr;
    logic [CW-1:0]          fifo_cnt;
    logic [1:0][CRED_W-1:0] cred;
    logic [HW-1:0]          hold_cnt;
    logic [WW-1:0]          wd_cnt;
    logic                   vc_turn;    // VC preferred when both have credits
    logic                   last_data;  // last non-credit issue was data

    logic [1:0]        grt_c, cred_nz;
    logic              ack_avail, ack_pop, push_ok, issue_data, wd_fire;
    logic              start_c, done_c, pkt_c, pop_c;
    logic [FLIT_W-1:0] flit_c;

    assign cred_nz[0] = (cred[0] != '0);
    assign cred_nz[1] = (cred[1] != '0);
    assign ack_avail  = (fifo_cnt != '0);
    assign push_ok    = ack_push && (fifo_cnt != FULL_CNT || ack_pop);

    always_comb begin
        state_nx   = state;
        grt_c      = 2'b00;
        ack_pop    = 1'b0;
        issue_data = 1'b0;
        start_c    = 1'b0;
        done_c     = 1'b0;
        pkt_c      = 1'b0;
        pop_c      = 1'b0;
        wd_fire    = 1'b0;
        flit_c     = '0;
        case (state)
            IDLE: if (tx_idle) begin
                if (cred_nz != 2'b00) begin
                    grt_c    = (cred_nz[0] && (!cred_nz[1] || !vc_turn)) ? 2'b01 : 2'b10;
                    state_nx = HOLD;
                end else if (ack_avail && (!data_req || last_data)) begin
                    ack_pop  = 1'b1;
                    start_c  = 1'b1;
                    flit_c   = fifo_mem[rd_ptr];
                    state_nx = HOLD;
                end else if (data_req) begin
                    issue_data = 1'b1;
                    start_c    = 1'b1;
                    flit_c     = data_flit;
                    state_nx   = SEND_DATA;
                end
            end
            SEND_DATA: begin
                flit_c = data_flit;
                if (get_data) begin
                    done_c = 1'b1;
                    pop_c  = 1'b1;
                    if (data_last) begin
                        pkt_c    = 1'b1;
                        state_nx = HOLD;
                    end
                end else if (wd_cnt == WD_LAST) begin
                    // PHY stalled: discard the flit so the source can move on
                    wd_fire  = 1'b1;
                    pop_c    = 1'b1;
                    state_nx = HOLD;
                end
            end
            HOLD: if (hold_cnt == HOLD_LAST) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Pulses are gated so every output reads 0 while reset is held.
    assign start_tx       = nRST & start_c;
    assign done_tx        = nRST & done_c;
    assign packet_done_tx = nRST & pkt_c;
    assign data_pop       = nRST & pop_c;
    assign grtcred_tx     = nRST ? grt_c : 2'b00;
    assign flit_tx        = nRST ? flit_c : '0;
    assign ack_full       = (fifo_cnt == FULL_CNT);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            wd_cnt      <= '0;
            vc_turn     <= 1'b0;
            last_data   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state    <= state_nx;
            hold_cnt <= (state == HOLD) ? hold_cnt + 1'b1 : '0;
            wd_cnt   <= (state == SEND_DATA && !get_data) ? wd_cnt + 1'b1 : '0;
            if (grt_c != 2'b00) vc_turn <= grt_c[0];
            if (ack_pop)         last_data <= 1'b0;
            else if (issue_data) last_data <= 1'b1;
            if (wd_fire) timeout_err <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ACK_DEPTH; i++) fifo_mem[i] <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
            ack_drop <= 1'b0;
        end else begin
            if (push_ok) begin
                fifo_mem[wr_ptr] <= ack_flit;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (ack_pop) rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !ack_pop)      fifo_cnt <= fifo_cnt + 1'b1;
            else if (ack_pop && !push_ok) fifo_cnt <= fifo_cnt - 1'b1;
            if (ack_push && !push_ok) ack_drop <= 1'b1;
        end
    end

    // A return and a grant on the same VC in one cycle cancel out.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cred     <= '0;
            cred_ovf <= 1'b0;
        end else begin
            for (int v = 0; v < 2; v++) begin
                if (cred_ret[v] && !grt_c[v]) begin
                    if (cred[v] == CRED_MAX) cred_ovf <= 1'b1;
                    else                     cred[v]  <= cred[v] + 1'b1;
                end else if (!cred_ret[v] && grt_c[v]) begin
                    cred[v] <= cred[v] - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_endnode_tx_scheduler.sv
// Directed bench for endnode_tx_scheduler: scoreboard of expected TX events
// plus direct checks of sticky flags, FIFO full and reset behaviour.
module tb_endnode_tx_scheduler;

    localparam int HOLD_CYC = 2;
    localparam int TIMEOUT  = 20;

    typedef struct packed {
        logic        start;
        logic [1:0]  grt;
        logic        done;
        logic        pkt;
        logic        pop;
        logic [31:0] flit;
    } ev_t;

    typedef struct {
        logic [31:0] flit;
        logic        last;
    } src_t;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        tx_idle, get_data, data_req, data_last, ack_push;
    logic [31:0] data_flit, ack_flit, flit_tx;
    logic [1:0]  cred_ret, grtcred_tx;
    logic        data_pop, ack_full, start_tx, done_tx, packet_done_tx;
    logic        ack_drop, cred_ovf, timeout_err;

    ev_t  exp_q[$];
    src_t src_q[$];
    int   ev_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic pop_seen = 1'b0;

    endnode_tx_scheduler #(
        .ACK_DEPTH(4), .CRED_W(4), .HOLD_CYC(HOLD_CYC), .TIMEOUT(TIMEOUT), .FLIT_W(32)
    ) dut (
        .CLK(CLK), .nRST(nRST), .tx_idle(tx_idle), .get_data(get_data),
        .data_req(data_req), .data_flit(data_flit), .data_last(data_last),
        .data_pop(data_pop), .ack_push(ack_push), .ack_flit(ack_flit),
        .ack_full(ack_full), .cred_ret(cred_ret), .flit_tx(flit_tx),
        .start_tx(start_tx), .done_tx(done_tx), .packet_done_tx(packet_done_tx),
        .grtcred_tx(grtcred_tx), .ack_drop(ack_drop), .cred_ovf(cred_ovf),
        .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Every issue/handoff pulse must match the next expected event, in order.
    always @(negedge CLK) begin
        ev_t obs, want;
        pop_seen = data_pop;
        obs = {start_tx, grtcred_tx, done_tx, packet_done_tx, data_pop, flit_tx};
        if (start_tx || grtcred_tx != 2'b00 || done_tx || packet_done_tx || data_pop) begin
            ev_cyc.push_back(cyc);
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_event: got %h want none", obs);
            end
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                checks++;
                assert (obs === want) else begin
                    errors++;
                    $error("FAIL event: got %h want %h", obs, want);
                end
            end
            checks++;
            assert (!(start_tx && grtcred_tx != 2'b00)) else begin
                errors++;
                $error("FAIL start_and_grant: got start=%b grt=%b want exclusive", start_tx, grtcred_tx);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "simulation bound exceeded");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic push_ev(input logic s, input logic [1:0] g, input logic d,
                           input logic p, input logic pp, input logic [31:0] f);
        ev_t e;
        e.start = s; e.grt = g; e.done = d; e.pkt = p; e.pop = pp; e.flit = f;
        exp_q.push_back(e);
    endtask

    task automatic exp_start(input logic [31:0] f);                 push_ev(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, f); endtask
    task automatic exp_grt(input logic [1:0] g);                    push_ev(1'b0, g, 1'b0, 1'b0, 1'b0, 32'h0); endtask
    task automatic exp_done(input logic [31:0] f, input logic last); push_ev(1'b0, 2'b00, 1'b1, last, 1'b1, f); endtask
    task automatic exp_drop(input logic [31:0] f);                  push_ev(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, f); endtask

    task automatic src_add(input logic [31:0] f, input logic last);
        src_t s;
        s.flit = f; s.last = last;
        src_q.push_back(s);
    endtask

    task automatic upd_src();
        if (src_q.size() != 0) begin
            data_req  = 1'b1;
            data_flit = src_q[0].flit;
            data_last = src_q[0].last;
        end else begin
            data_req  = 1'b0;
            data_flit = 32'h0;
            data_last = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        if (pop_seen && src_q.size() != 0) src_q.delete(0);
        pop_seen = 1'b0;
        upd_src();
    endtask

    task automatic ack_in(input logic [31:0] f);
        ack_push = 1'b1;
        ack_flit = f;
        tick();
        ack_push = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    function automatic logic [63:0] all_out();
        return {start_tx, done_tx, packet_done_tx, grtcred_tx, data_pop,
                ack_full, ack_drop, cred_ovf, timeout_err, flit_tx};
    endfunction

    initial begin
        // reset with every requester active: outputs must stay quiet
        nRST = 1'b0; tx_idle = 1'b1; get_data = 1'b1; cred_ret = 2'b11;
        ack_push = 1'b1; ack_flit = 32'hA0A0_0000;
        src_add(32'hDEAD_0000, 1'b1);
        upd_src();
        #2;
        chk("reset_outputs", all_out(), 0);
        tick(); tick();
        chk("reset_outputs_held", all_out(), 0);
        cred_ret = 2'b00; ack_push = 1'b0; get_data = 1'b0;
        src_q.delete(); upd_src();
        nRST = 1'b1;
        repeat (3) tick();
        chk("post_reset_ack_full", ack_full, 0);

        // credit return on both VCs: VC0 first, then VC1
        cred_ret = 2'b11;
        tick();
        cred_ret = 2'b00;
        ev_cyc.delete();
        exp_grt(2'b01); exp_grt(2'b10);
        drain("credit_drain", 20);
        chk("credit_gap", ev_cyc[1] - ev_cyc[0], HOLD_CYC + 1);
        repeat (6) tick();
        chk("credit_no_ovf", cred_ovf, 0);

        // 3-flit packet with PHY taking each flit immediately
        get_data = 1'b1;
        src_add(32'hF000_0000, 1'b0); src_add(32'hF000_0001, 1'b0); src_add(32'hF000_0002, 1'b1);
        upd_src();
        exp_start(32'hF000_0000);
        exp_done(32'hF000_0000, 1'b0); exp_done(32'hF000_0001, 1'b0); exp_done(32'hF000_0002, 1'b1);
        drain("packet_drain", 30);
        repeat (4) tick();

        // ACK and data both pending: alternate
        tx_idle = 1'b0;
        ack_in(32'hAC00_0000);
        ack_in(32'hAC00_0001);
        src_add(32'hD000_0000, 1'b0); src_add(32'hD000_0001, 1'b1);
        src_add(32'hD000_0002, 1'b0); src_add(32'hD000_0003, 1'b1);
        upd_src();
        exp_start(32'hAC00_0000);
        exp_start(32'hD000_0000); exp_done(32'hD000_0000, 1'b0); exp_done(32'hD000_0001, 1'b1);
        exp_start(32'hAC00_0001);
        exp_start(32'hD000_0002); exp_done(32'hD000_0002, 1'b0); exp_done(32'hD000_0003, 1'b1);
        tx_idle = 1'b1;
        drain("rr_drain", 100);
        repeat (4) tick();

        // credit returned mid-packet waits for packet end, then beats the ACK
        get_data = 1'b0;
        src_add(32'hC000_0000, 1'b0); src_add(32'hC000_0001, 1'b1);
        upd_src();
        exp_start(32'hC000_0000);
        drain("midpkt_start", 20);
        tick(); tick();
        cred_ret = 2'b01;
        tick();
        cred_ret = 2'b00;
        ack_in(32'hAC00_0002);
        ev_cyc.delete();
        exp_done(32'hC000_0000, 1'b0); exp_done(32'hC000_0001, 1'b1);
        exp_grt(2'b01); exp_start(32'hAC00_0002);
        get_data = 1'b1;
        drain("midpkt_drain", 40);
        chk("midpkt_grant_gap", ev_cyc[2] - ev_cyc[1], HOLD_CYC + 1);
        repeat (4) tick();

        // FIFO: fill, overflow drop, then push+pop while full
        tx_idle = 1'b0;
        ack_in(32'hB000_0000); ack_in(32'hB000_0001); ack_in(32'hB000_0002);
        chk("fifo_not_full_3", ack_full, 0);
        ack_in(32'hB000_0003);
        chk("fifo_full_4", ack_full, 1);
        chk("fifo_no_drop_4", ack_drop, 0);
        ack_in(32'hB000_0004);
        chk("fifo_drop_5", ack_drop, 1);
        exp_start(32'hB000_0000); exp_start(32'hB000_0001); exp_start(32'hB000_0002);
        exp_start(32'hB000_0003); exp_start(32'hB000_0005);
        tx_idle = 1'b1;
        ack_in(32'hB000_0005);
        chk("fifo_full_after_pushpop", ack_full, 1);
        drain("fifo_drain", 60);
        chk("fifo_empty_after", ack_full, 0);
        repeat (4) tick();

        // credit saturation, then a grant coinciding with a return
        tx_idle = 1'b0;
        cred_ret = 2'b01;
        repeat (15) tick();
        chk("cred_no_ovf_15", cred_ovf, 0);
        tick();
        chk("cred_ovf_16", cred_ovf, 1);
        for (int i = 0; i < 16; i++) exp_grt(2'b01);
        tx_idle = 1'b1;
        tick();
        cred_ret = 2'b00;
        drain("cred_sat_drain", 100);
        repeat (6) tick();

        // watchdog: PHY never takes the flit
        get_data = 1'b0;
        chk("timeout_err_pre", timeout_err, 0);
        src_add(32'hE000_0000, 1'b1);
        upd_src();
        ev_cyc.delete();
        exp_start(32'hE000_0000); exp_drop(32'hE000_0000);
        drain("timeout_drain", 60);
        chk("timeout_gap", ev_cyc[1] - ev_cyc[0], TIMEOUT);
        chk("timeout_err_set", timeout_err, 1);
        repeat (4) tick();

        // reset mid-packet clears everything at once
        src_add(32'h6000_0000, 1'b0); src_add(32'h6000_0001, 1'b0); src_add(32'h6000_0002, 1'b1);
        upd_src();
        exp_start(32'h6000_0000);
        drain("rst_pkt_start", 20);
        tick(); tick();
        nRST = 1'b0;
        #1;
        chk("reset_midpkt_outputs", all_out(), 0);
        src_q.delete(); upd_src();
        tick();
        nRST = 1'b1;
        get_data = 1'b1;
        src_add(32'h7000_0000, 1'b1);
        upd_src();
        exp_start(32'h7000_0000); exp_done(32'h7000_0000, 1'b1);
        drain("post_reset_pkt", 20);
        chk("post_reset_sticky", {ack_drop, cred_ovf, timeout_err}, 0);
        repeat (5) tick();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
